zigzag_rle_encoder: RTL and testbench
=====================================

ZIGZAG_RLE_ENCODER -- requirements
Module: zigzag_rle_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, coefficient width (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 64, coefficients per block.
REQ-003 SHALL have parameter RUN_WIDTH, default 4, zero-run field width.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port zigzag_pix_in  input  640  one block in zigzag order; coefficient k at bits [10k+9:10k], k=0 is DC.
REQ-007 SHALL have port block_valid  input  1  zigzag_pix_in holds a valid block.
REQ-008 SHALL have port block_ready  output  1  encoder can accept a block.
REQ-009 SHALL have port rle_valid  output  1  symbol fields valid.
REQ-010 SHALL have port rle_ready  input  1  downstream accepts the symbol.
REQ-011 SHALL have port rle_run  output  RUN_WIDTH  count of zero AC coefficients preceding rle_value.
REQ-012 SHALL have port rle_value  output  DATA_WIDTH  coefficient value, unchanged from input.
REQ-013 SHALL have port rle_is_dc  output  1  symbol is the DC coefficient.
REQ-014 SHALL have port rle_eob  output  1  symbol is end-of-block.
REQ-015 SHALL have port busy  output  1  a block is being encoded (state not IDLE).

Function
REQ-016 SHALL accept a block on block_valid && block_ready, registering all 640 bits and the index of the last nonzero AC coefficient (last_nz; none if all AC are zero).
REQ-017 SHALL assert block_ready only in state IDLE.
REQ-018 SHALL use states IDLE, EMIT_DC, SCAN, EMIT_EOB; IDLE->EMIT_DC on accept; EMIT_DC->SCAN on DC handshake, or ->EMIT_EOB if no nonzero AC; SCAN->EMIT_EOB after the symbol for last_nz is handshaked when last_nz<63; SCAN->IDLE after that handshake when last_nz=63; EMIT_EOB->IDLE on EOB handshake.
REQ-019 SHALL present the DC symbol (rle_is_dc=1, rle_run=0, rle_value=coef0, including coef0=0) with rle_valid high on the cycle after acceptance.
REQ-020 SHALL in SCAN examine one AC coefficient per cycle from index 1 upward, only while the output register is empty or being handshaked that cycle.
REQ-021 SHALL increment the run counter on a zero coefficient when run<15; on a zero coefficient with run=15 SHALL emit ZRL (rle_run=15, rle_value=0) and clear run.
REQ-022 SHALL on a nonzero coefficient emit (rle_run=run, rle_value=coef) and clear run.
REQ-023 SHALL not examine indices beyond last_nz; trailing zeros produce no ZRL.
REQ-024 SHALL emit EOB as rle_eob=1, rle_run=0, rle_value=0; SHALL emit no EOB when last_nz=63.
REQ-025 SHALL hold all rle_* outputs stable while rle_valid && !rle_ready.
REQ-026 SHALL sustain one symbol per cycle with rle_ready high, except one cycle per non-emitting zero.
REQ-027 SHALL assert exactly one of rle_is_dc, rle_eob or neither per symbol; flags low when rle_valid low.
REQ-028 SHALL ignore block_valid outside IDLE; a block held valid during encoding SHALL be accepted the cycle after the final handshake returns to IDLE.

Reset
REQ-029 SHALL on reset (any state, including mid-block) enter IDLE, discard the block, clear run and index, and drive rle_valid=0, rle_run=0, rle_value=0, rle_is_dc=0, rle_eob=0, busy=0, block_ready=1 on the following cycle.

Structure
REQ-030 SHALL take DATA_WIDTH, DEPTH, RUN_WIDTH, ZRL_RUN=15 and the state encoding from the shared package jpeg_enc_pkg.
REQ-031 SHALL implement last_nz detection in sub-module last_nonzero_finder (63-input priority encoder plus all-zero flag), combinational, registered at acceptance.

Verification
REQ-032 SHALL cover: DC=0x005, all AC zero -> (dc,0,0x005), then EOB; two symbols total.
REQ-033 SHALL cover: DC=0x3FD, coef1=7, coef63=0x3FF, others zero -> (dc,0,0x3FD), (0,7), ZRL x3, (13,0x3FF), no EOB.
REQ-034 SHALL cover: only coef17=2 nonzero, DC=0 -> (dc,0,0), ZRL, (0,2), EOB.
REQ-035 SHALL cover: REQ-033 block with rle_ready toggling 1/0 each cycle -> identical symbol sequence, outputs stable on every stall cycle.
REQ-036 SHALL cover: reset asserted after third symbol of REQ-033 block -> next cycle all outputs zero, block_ready=1; a following REQ-032 block encodes correctly.
REQ-037 SHALL cover: two REQ-034 blocks with block_valid held high -> second accepted the cycle after first EOB handshake; eight symbols in order.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared constants and state encoding for the JPEG entropy-coding front end.
package jpeg_enc_pkg;
    localparam int DATA_WIDTH = 10;
    localparam int DEPTH      = 64;
    localparam int RUN_WIDTH  = 4;
    localparam int ZRL_RUN    = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT_DC,
        ST_SCAN,
        ST_EMIT_EOB
    } rle_state_t;
endpackage

// File: rtl/last_nonzero_finder.sv
// Priority encoder over the AC coefficients: index of the highest nonzero one,
// plus a flag for the all-zero case.
module last_nonzero_finder
    import jpeg_enc_pkg::*;
#(
    parameter int DATA_WIDTH = jpeg_enc_pkg::DATA_WIDTH,
    parameter int DEPTH      = jpeg_enc_pkg::DEPTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic [DATA_WIDTH*(DEPTH-1)-1:0] i_acCoefs,
    output logic [IDX_WIDTH-1:0]            o_lastNz,
    output logic                            o_allZero
);

    // Later (higher) indices overwrite earlier hits, so the last match wins.
    always_comb begin
        o_lastNz  = '0;
        o_allZero = 1'b1;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (i_acCoefs[k*DATA_WIDTH +: DATA_WIDTH] != '0) begin
                o_lastNz  = IDX_WIDTH'(k + 1);
                o_allZero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Run-length encoder for one zigzag-ordered block: DC symbol, (run,value) AC
// symbols with ZRL for 16-zero runs, and EOB when the block ends in zeros.
module zigzag_rle_encoder
    import jpeg_enc_pkg::*;
#(
    parameter int DATA_WIDTH = jpeg_enc_pkg::DATA_WIDTH,
    parameter int DEPTH      = jpeg_enc_pkg::DEPTH,
    parameter int RUN_WIDTH  = jpeg_enc_pkg::RUN_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH*DEPTH-1:0] zigzag_pix_in,
    input  logic                        block_valid,
    output logic                        block_ready,
    output logic                        rle_valid,
    input  logic                        rle_ready,
    output logic [RUN_WIDTH-1:0]        rle_run,
    output logic [DATA_WIDTH-1:0]       rle_value,
    output logic                        rle_is_dc,
    output logic                        rle_eob,
    output logic                        busy
);
    localparam int                   IDX_WIDTH = $clog2(DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DEPTH - 1);
    localparam logic [RUN_WIDTH-1:0] ZRL       = RUN_WIDTH'(ZRL_RUN);

    rle_state_t                  r_state, w_stateNext;
    logic [DATA_WIDTH*DEPTH-1:0] r_block;
    logic [IDX_WIDTH-1:0]        r_lastNz, w_lastNz;
    logic                        r_allZero, w_allZero;
    logic [IDX_WIDTH-1:0]        r_idx, w_idxNext;
    logic [RUN_WIDTH-1:0]        r_run, w_runNext;
    logic                        r_done, w_doneNext;
    logic                        r_outValid;
    logic [RUN_WIDTH-1:0]        r_outRun;
    logic [DATA_WIDTH-1:0]       r_outValue;
    logic                        r_outDc, r_outEob;
    logic                        w_accept, w_handshake, w_scanStep, w_load, w_clear;
    logic [RUN_WIDTH-1:0]        w_ldRun;
    logic [DATA_WIDTH-1:0]       w_ldValue, w_coef;
    logic                        w_ldDc, w_ldEob;

    last_nonzero_finder #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_lastNz (
        .i_acCoefs(zigzag_pix_in[DATA_WIDTH*DEPTH-1:DATA_WIDTH]),
        .o_lastNz (w_lastNz),
        .o_allZero(w_allZero)
    );

    assign w_accept    = (r_state == ST_IDLE) && block_valid;
    assign w_handshake = r_outValid && rle_ready;
    assign w_coef      = r_block[r_idx*DATA_WIDTH +: DATA_WIDTH];

    // The first AC step is taken on the DC handshake itself so DC and the
    // first AC symbol go out back to back.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_runNext   = r_run;
        w_doneNext  = r_done;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_ldRun     = '0;
        w_ldValue   = '0;
        w_ldDc      = 1'b0;
        w_ldEob     = 1'b0;
        w_scanStep  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (block_valid) begin
                    w_stateNext = ST_EMIT_DC;
                    w_load      = 1'b1;
                    w_ldDc      = 1'b1;
                    w_ldValue   = zigzag_pix_in[DATA_WIDTH-1:0];
                    w_idxNext   = IDX_WIDTH'(1);
                    w_runNext   = '0;
                    w_doneNext  = 1'b0;
                end
            end
            ST_EMIT_DC: begin
                if (w_handshake) begin
                    if (r_allZero) begin
                        w_stateNext = ST_EMIT_EOB;
                        w_load      = 1'b1;
                        w_ldEob     = 1'b1;
                    end else begin
                        w_stateNext = ST_SCAN;
                        w_scanStep  = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (r_done) begin
                    if (w_handshake) begin
                        if (r_lastNz == LAST_IDX) begin
                            w_stateNext = ST_IDLE;
                            w_clear     = 1'b1;
                        end else begin
                            w_stateNext = ST_EMIT_EOB;
                            w_load      = 1'b1;
                            w_ldEob     = 1'b1;
                        end
                    end
                end else if (!r_outValid || w_handshake) begin
                    w_scanStep = 1'b1;
                end
            end
            ST_EMIT_EOB: begin
                if (w_handshake) begin
                    w_stateNext = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase

        if (w_scanStep) begin
            w_idxNext = r_idx + 1'b1;
            if (w_coef != '0) begin
                w_load     = 1'b1;
                w_ldRun    = r_run;
                w_ldValue  = w_coef;
                w_runNext  = '0;
                w_doneNext = (r_idx == r_lastNz);
            end else if (r_run == ZRL) begin
                w_load    = 1'b1;
                w_ldRun   = ZRL;
                w_runNext = '0;
            end else begin
                w_runNext = r_run + 1'b1;
                w_clear   = w_handshake;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_run      <= '0;
            r_done     <= 1'b0;
            r_lastNz   <= '0;
            r_allZero  <= 1'b1;
            r_outValid <= 1'b0;
            r_outRun   <= '0;
            r_outValue <= '0;
            r_outDc    <= 1'b0;
            r_outEob   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_run   <= w_runNext;
            r_done  <= w_doneNext;
            if (w_accept) begin
                r_lastNz  <= w_lastNz;
                r_allZero <= w_allZero;
            end
            if (w_load) begin
                r_outValid <= 1'b1;
                r_outRun   <= w_ldRun;
                r_outValue <= w_ldValue;
                r_outDc    <= w_ldDc;
                r_outEob   <= w_ldEob;
            end else if (w_clear) begin
                r_outValid <= 1'b0;
                r_outRun   <= '0;
                r_outValue <= '0;
                r_outDc    <= 1'b0;
                r_outEob   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_block <= zigzag_pix_in;
        end
    end

    assign block_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign rle_valid   = r_outValid;
    assign rle_run     = r_outRun;
    assign rle_value   = r_outValue;
    assign rle_is_dc   = r_outDc;
    assign rle_eob     = r_outEob;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Self-checking bench for zigzag_rle_encoder: directed blocks plus random
// sparse blocks, compared against a JPEG-style run-length reference model.
module tb_zigzag_rle_encoder;

    localparam int DW     = 10;
    localparam int NC     = 64;
    localparam int RW     = 4;
    localparam int BUDGET = 2000;

    logic              clock = 1'b0;
    logic              reset;
    logic [DW*NC-1:0]  zigzag_pix_in;
    logic              block_valid;
    logic              block_ready;
    logic              rle_valid;
    logic              rle_ready;
    logic [RW-1:0]     rle_run;
    logic [DW-1:0]     rle_value;
    logic              rle_is_dc;
    logic              rle_eob;
    logic              busy;

    typedef struct packed {
        logic [RW-1:0] run;
        logic [DW-1:0] value;
        logic          dc;
        logic          eob;
    } sym_t;

    logic [DW-1:0] blk [NC];
    sym_t          expQ [$];
    int            errorCount = 0;
    int            checkCount = 0;
    bit            didReset;

    zigzag_rle_encoder dut (
        .clock        (clock),
        .reset        (reset),
        .zigzag_pix_in(zigzag_pix_in),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .rle_valid    (rle_valid),
        .rle_ready    (rle_ready),
        .rle_run      (rle_run),
        .rle_value    (rle_value),
        .rle_is_dc    (rle_is_dc),
        .rle_eob      (rle_eob),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void clearBlock();
        for (int k = 0; k < NC; k++) blk[k] = '0;
    endfunction

    function automatic logic [DW-1:0] randNonZero();
        logic [DW-1:0] v;
        v = DW'($urandom);
        if (v == '0) v = DW'(1);
        return v;
    endfunction

    // Reference: DC first, then for each nonzero AC emit ZRLs while more than
    // 15 zeros precede it, then (zeros, value); EOB only if trailing zeros exist.
    function automatic void buildExpected();
        int   last  = 0;
        int   zeros = 0;
        sym_t s;
        s = '{run: '0, value: blk[0], dc: 1'b1, eob: 1'b0};
        expQ.push_back(s);
        for (int k = 1; k < NC; k++) if (blk[k] != '0) last = k;
        for (int k = 1; k <= last; k++) begin
            if (blk[k] == '0) begin
                zeros++;
            end else begin
                while (zeros > 15) begin
                    s = '{run: RW'(15), value: '0, dc: 1'b0, eob: 1'b0};
                    expQ.push_back(s);
                    zeros -= 16;
                end
                s = '{run: RW'(zeros), value: blk[k], dc: 1'b0, eob: 1'b0};
                expQ.push_back(s);
                zeros = 0;
            end
        end
        if (last != NC - 1) begin
            s = '{run: '0, value: '0, dc: 1'b0, eob: 1'b1};
            expQ.push_back(s);
        end
    endfunction

    function automatic void packBlock();
        for (int k = 0; k < NC; k++) zigzag_pix_in[k*DW +: DW] = blk[k];
    endfunction

    // Presents the packed block nBlocks times (valid held high) and drains the
    // expected queue. readyMode: 0 always ready, 1 toggling, 2 random.
    task automatic applyStimulus(input int nBlocks, input int readyMode,
                                 input int resetAfter, output bit resetHit);
        int   cycles     = 0;
        int   blocksLeft = nBlocks;
        int   handshakes = 0;
        int   acceptCnt  = 0;
        int   lastEob    = -100;
        bit   stalled    = 1'b0;
        bit   justAccept = 1'b0;
        sym_t held       = '0;
        sym_t obs;
        sym_t exp;
        resetHit    = 1'b0;
        block_valid = 1'b1;
        while ((expQ.size() > 0 || blocksLeft > 0) && cycles < BUDGET) begin
            cycles++;
            if (blocksLeft == 0) block_valid = 1'b0;
            obs = '{run: rle_run, value: rle_value, dc: rle_is_dc, eob: rle_eob};
            if (stalled) checkOutput("stallHold", 32'(obs), 32'(held));
            if (justAccept) checkOutput("dcLatency", 32'({rle_valid, rle_is_dc, rle_eob}), 32'b110);
            if (!rle_valid) checkOutput("idleFlags", 32'({rle_is_dc, rle_eob}), 32'd0);
            else            checkOutput("oneFlag", 32'(rle_is_dc & rle_eob), 32'd0);
            case (readyMode)
                0:       rle_ready = 1'b1;
                1:       rle_ready = (cycles % 2) == 1;
                default: rle_ready = 1'($urandom_range(0, 1));
            endcase
            justAccept = 1'b0;
            if (block_valid && block_ready && blocksLeft > 0) begin
                if (acceptCnt > 0) checkOutput("acceptGap", 32'(cycles - lastEob), 32'd1);
                blocksLeft--;
                acceptCnt++;
                justAccept = 1'b1;
            end
            stalled = rle_valid && !rle_ready;
            held    = obs;
            if (rle_valid && rle_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraSymbol", 32'(rle_valid), 32'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("symbol", 32'(obs), 32'(exp));
                end
                if (rle_eob) lastEob = cycles;
                handshakes++;
                if (resetAfter > 0 && handshakes == resetAfter) begin
                    resetHit = 1'b1;
                    break;
                end
            end
            @(negedge clock);
        end
        if (cycles >= BUDGET) checkOutput("pendingWork", 32'(expQ.size() + blocksLeft), 32'd0);
        block_valid = 1'b0;
    endtask

    task automatic runBlock(input int nBlocks, input int readyMode);
        bit hit;
        packBlock();
        for (int b = 0; b < nBlocks; b++) buildExpected();
        applyStimulus(nBlocks, readyMode, 0, hit);
        checkOutput("idleAfter", 32'({block_ready, busy, rle_valid}), 32'b100);
    endtask

    task automatic setBlockA();
        clearBlock();
        blk[0] = 10'h005;
    endtask

    task automatic setBlockB();
        clearBlock();
        blk[0]  = 10'h3FD;
        blk[1]  = 10'd7;
        blk[63] = 10'h3FF;
    endtask

    task automatic setBlockC();
        clearBlock();
        blk[17] = 10'd2;
    endtask

    initial begin
        reset         = 1'b1;
        block_valid   = 1'b0;
        rle_ready     = 1'b0;
        zigzag_pix_in = '0;
        repeat (3) @(negedge clock);
        checkOutput("resetState",
                    32'({rle_valid, rle_run, rle_value, rle_is_dc, rle_eob, busy, block_ready}), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        setBlockA(); runBlock(1, 0);
        setBlockB(); runBlock(1, 0);
        setBlockC(); runBlock(1, 0);
        setBlockB(); runBlock(1, 1);

        // Reset in the middle of a block, then a fresh block must encode cleanly.
        setBlockB();
        packBlock();
        buildExpected();
        applyStimulus(1, 0, 3, didReset);
        checkOutput("resetReached", 32'(didReset), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midReset",
                    32'({rle_valid, rle_run, rle_value, rle_is_dc, rle_eob, busy, block_ready}), 32'd1);
        expQ.delete();
        setBlockA(); runBlock(1, 0);

        setBlockC(); runBlock(2, 0);

        for (int b = 0; b < 20; b++) begin
            int density;
            clearBlock();
            blk[0]  = DW'($urandom);
            density = $urandom_range(1, 25);
            for (int k = 1; k < NC; k++)
                if ($urandom_range(0, 99) < density) blk[k] = randNonZero();
            if (b % 5 == 0) blk[63] = randNonZero();
            if (b % 7 == 3) for (int k = 1; k < NC; k++) blk[k] = '0;
            runBlock(1 + (b % 3 == 1 ? 1 : 0), 2);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
